// File: rtl/aidc_lite_comp_pingpong_buf.sv
// Multi-bank ping-pong staging buffer: the fill side writes and commits banks, the drain side reads and releases them.
// Reads return one cycle after rden_i; wr_avail_o/rd_valid_o gate each side and illegal requests only set the sticky err_o.
module aidc_lite_comp_pingpong_buf #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BE_W      = DATA_W / 8,
    localparam int BANK_W   = $clog2(NUM_BANKS),
    localparam int CNT_W    = $clog2(NUM_BANKS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              wr_avail_o,
    output logic [BANK_W-1:0] wr_bank_o,
    input  logic              wren_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [BE_W-1:0]   wbe_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wr_commit_i,
    output logic              rd_valid_o,
    output logic [BANK_W-1:0] rd_bank_o,
    input  logic              rden_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    input  logic              rd_release_i,
    output logic [CNT_W-1:0]  full_cnt_o,
    output logic              err_o
);

    // One bit per bank: 0 = owned by the fill side, 1 = owned by the drain side.
    logic [NUM_BANKS-1:0] state_q, state_d;
    logic [BANK_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic [CNT_W-1:0]     full_cnt;

    logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];

    logic wr_avail, rd_valid;
    logic do_write, do_commit, do_read, do_release, violation;

    function automatic logic [BANK_W-1:0] ptr_inc(input logic [BANK_W-1:0] p);
        return (p == BANK_W'(NUM_BANKS - 1)) ? '0 : p + BANK_W'(1);
    endfunction

    assign wr_avail   = ~state_q[wr_ptr_q];
    assign rd_valid   = state_q[rd_ptr_q];

    assign do_write   = wren_i       & wr_avail;
    assign do_commit  = wr_commit_i  & wr_avail;
    assign do_read    = rden_i       & rd_valid;
    assign do_release = rd_release_i & rd_valid;
    assign violation  = ((wren_i | wr_commit_i) & ~wr_avail) |
                        ((rden_i | rd_release_i) & ~rd_valid);

    // Commit and release always touch different banks, so both updates can apply.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        err_d         = err_q | violation;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        if (do_commit) begin
            state_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (do_release) begin
            state_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        if (do_read) begin
            rdata_d       = mem_q[rd_ptr_q][raddr_i];
            rdata_valid_d = 1'b1;
        end
    end

    always_comb begin
        full_cnt = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            full_cnt = full_cnt + CNT_W'(state_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // Storage is deliberately not reset; reset only revokes ownership.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wbe_i[k]) begin
                    mem_q[wr_ptr_q][waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign wr_avail_o    = wr_avail;
    assign wr_bank_o     = wr_ptr_q;
    assign rd_valid_o    = rd_valid;
    assign rd_bank_o     = rd_ptr_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign full_cnt_o    = full_cnt;
    assign err_o         = err_q;

endmodule

// File: tb/tb_aidc_lite_comp_pingpong_buf.sv
// Bench for the ping-pong buffer: a 2x16x64 instance and a 3x8x32 instance against a bank-ownership model.
module tb_aidc_lite_comp_pingpong_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wren[2], commit[2], rden[2], rel[2];
    logic [3:0]  waddr[2], raddr[2];
    logic [7:0]  wbe[2];
    logic [63:0] wdata[2];

    logic        d0_avail, d0_wbank, d0_valid, d0_rbank, d0_rdv, d0_err;
    logic [63:0] d0_rdata;
    logic [1:0]  d0_cnt;
    logic        d1_avail, d1_valid, d1_rdv, d1_err;
    logic [1:0]  d1_wbank, d1_rbank, d1_cnt;
    logic [31:0] d1_rdata;

    aidc_lite_comp_pingpong_buf u_dut0 (
        .clk(clk), .rst(rst),
        .wr_avail_o(d0_avail), .wr_bank_o(d0_wbank),
        .wren_i(wren[0]), .waddr_i(waddr[0]), .wbe_i(wbe[0]), .wdata_i(wdata[0]),
        .wr_commit_i(commit[0]),
        .rd_valid_o(d0_valid), .rd_bank_o(d0_rbank),
        .rden_i(rden[0]), .raddr_i(raddr[0]),
        .rdata_o(d0_rdata), .rdata_valid_o(d0_rdv),
        .rd_release_i(rel[0]), .full_cnt_o(d0_cnt), .err_o(d0_err)
    );

    aidc_lite_comp_pingpong_buf #(.DATA_W(32), .DEPTH(8), .NUM_BANKS(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .wr_avail_o(d1_avail), .wr_bank_o(d1_wbank),
        .wren_i(wren[1]), .waddr_i(waddr[1][2:0]), .wbe_i(wbe[1][3:0]), .wdata_i(wdata[1][31:0]),
        .wr_commit_i(commit[1]),
        .rd_valid_o(d1_valid), .rd_bank_o(d1_rbank),
        .rden_i(rden[1]), .raddr_i(raddr[1][2:0]),
        .rdata_o(d1_rdata), .rdata_valid_o(d1_rdv),
        .rd_release_i(rel[1]), .full_cnt_o(d1_cnt), .err_o(d1_err)
    );

    logic        o_avail[2], o_valid[2], o_rdv[2], o_err[2];
    logic [1:0]  o_wbank[2], o_rbank[2], o_cnt[2];
    logic [63:0] o_rdata[2];
    assign o_avail[0] = d0_avail;          assign o_avail[1] = d1_avail;
    assign o_valid[0] = d0_valid;          assign o_valid[1] = d1_valid;
    assign o_rdv[0]   = d0_rdv;            assign o_rdv[1]   = d1_rdv;
    assign o_err[0]   = d0_err;            assign o_err[1]   = d1_err;
    assign o_wbank[0] = {1'b0, d0_wbank};  assign o_wbank[1] = d1_wbank;
    assign o_rbank[0] = {1'b0, d0_rbank};  assign o_rbank[1] = d1_rbank;
    assign o_cnt[0]   = d0_cnt;            assign o_cnt[1]   = d1_cnt;
    assign o_rdata[0] = d0_rdata;          assign o_rdata[1] = {32'h0, d1_rdata};

    // Model: bank ownership flags, modulo pointers, a counter of full banks and a word array.
    int          NB[2]  = '{2, 3};
    int          DEP[2] = '{16, 8};
    int          BEW[2] = '{8, 4};
    bit          st[2][3];
    int          wp[2], rp[2], cnt[2];
    bit          m_err[2], m_rvld[2];
    logic [63:0] m_rdata[2];
    logic [63:0] mm[2][3][16];
    bit          started = 1'b0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [63:0] dmask(input int c);
        return (c == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [7:0] bemask(input int c);
        return (c == 0) ? 8'hFF : 8'h0F;
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int b = 0; b < 3; b++) st[c][b] = 1'b0;
                wp[c] = 0; rp[c] = 0; cnt[c] = 0;
                m_err[c] = 1'b0; m_rvld[c] = 1'b0; m_rdata[c] = 64'h0;
            end else begin : step
                bit av, vl;
                av = !st[c][wp[c]];
                vl = st[c][rp[c]];
                if (((wren[c] || commit[c]) && !av) || ((rden[c] || rel[c]) && !vl))
                    m_err[c] = 1'b1;
                m_rvld[c] = 1'b0;
                if (rden[c] && vl) begin
                    m_rdata[c] = mm[c][rp[c]][raddr[c]];
                    m_rvld[c]  = 1'b1;
                end
                if (wren[c] && av)
                    for (int k = 0; k < BEW[c]; k++)
                        if (wbe[c][k]) mm[c][wp[c]][waddr[c]][8*k +: 8] = wdata[c][8*k +: 8];
                if (commit[c] && av) begin
                    st[c][wp[c]] = 1'b1; wp[c] = (wp[c] + 1) % NB[c]; cnt[c]++;
                end
                if (rel[c] && vl) begin
                    st[c][rp[c]] = 1'b0; rp[c] = (rp[c] + 1) % NB[c]; cnt[c]--;
                end
            end
        end
        if (rst) started = 1'b1;
    end

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d @%0t: got %h expected %h", nm, c, $time, act, exp);
        end
    endtask

    // Bytes never written are unknown in the model and are not compared.
    task automatic chk_data(input int c, input logic [63:0] act, input logic [63:0] exp);
        bit any, bad;
        any = 1'b0; bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!$isunknown(exp[8*k +: 8])) begin
                any = 1'b1;
                if (act[8*k +: 8] !== exp[8*k +: 8]) bad = 1'b1;
            end
        end
        if (any) begin
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL rdata cfg%0d @%0t: got %h expected %h", c, $time, act, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int c = 0; c < 2; c++) begin
                chk("wr_avail", c, 64'(o_avail[c]), 64'(!st[c][wp[c]]));
                chk("rd_valid", c, 64'(o_valid[c]), 64'(st[c][rp[c]]));
                chk("wr_bank", c, 64'(o_wbank[c]), 64'(wp[c]));
                chk("rd_bank", c, 64'(o_rbank[c]), 64'(rp[c]));
                chk("full_cnt", c, 64'(o_cnt[c]), 64'(cnt[c]));
                chk("err", c, 64'(o_err[c]), 64'(m_err[c]));
                chk("rdata_valid", c, 64'(o_rdv[c]), 64'(m_rvld[c]));
                chk_data(c, o_rdata[c], m_rdata[c]);
            end
        end
    end

    task automatic clr();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            wren[c] = 1'b0; commit[c] = 1'b0; rden[c] = 1'b0; rel[c] = 1'b0;
            waddr[c] = 4'h0; raddr[c] = 4'h0; wbe[c] = 8'h0; wdata[c] = 64'h0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clr();
        end
    endtask

    task automatic drive(input int c, input bit we, input int wa, input logic [7:0] be,
                         input logic [63:0] wd, input bit cm, input bit re, input int ra, input bit rl);
        @(negedge clk);
        clr();
        wren[c] = we; waddr[c] = 4'(wa); wbe[c] = be & bemask(c); wdata[c] = wd & dmask(c);
        commit[c] = cm; rden[c] = re; raddr[c] = 4'(ra); rel[c] = rl;
    endtask

    function automatic logic [63:0] pat(input int r, input int a);
        return {32'h0, 8'hA5, 8'(r), 8'(a), 8'h3C};
    endfunction

    task automatic fill(input int c, input int r);
        for (int a = 0; a < DEP[c]; a++) drive(c, 1, a, 8'hFF, pat(r, a), 0, 0, 0, 0);
        drive(c, 0, 0, 8'h0, 64'h0, 1, 0, 0, 0);
    endtask

    task automatic drain(input int c, input int r);
        for (int a = 0; a < DEP[c]; a++) begin
            drive(c, 0, 0, 8'h0, 64'h0, 0, 1, a, 0);
            idle(1);
            chk("round_data", c, o_rdata[c], pat(r, a));
        end
        drive(c, 0, 0, 8'h0, 64'h0, 0, 0, 0, 1);
    endtask

    task automatic rand_cycle(input int c);
        bit av, vl;
        @(negedge clk);
        clr();
        av = !st[c][wp[c]];
        vl = st[c][rp[c]];
        wren[c]   = av && ($urandom_range(1, 0) == 1);
        waddr[c]  = 4'($urandom_range(DEP[c] - 1, 0));
        wbe[c]    = 8'($urandom) & bemask(c);
        wdata[c]  = {$urandom, $urandom} & dmask(c);
        commit[c] = av && ($urandom_range(7, 0) == 0);
        rden[c]   = vl && ($urandom_range(1, 0) == 1);
        raddr[c]  = 4'($urandom_range(DEP[c] - 1, 0));
        rel[c]    = vl && ($urandom_range(5, 0) == 0);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        idle(2);
        for (int c = 0; c < 2; c++) begin
            chk("reset_avail", c, 64'(o_avail[c]), 64'd1);
            chk("reset_valid", c, 64'(o_valid[c]), 64'd0);
            chk("reset_cnt", c, 64'(o_cnt[c]), 64'd0);
            chk("reset_err", c, 64'(o_err[c]), 64'd0);
            chk("reset_rdv", c, 64'(o_rdv[c]), 64'd0);
        end

        // Byte-enable merge on bank 0.
        drive(0, 1, 3, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 0, 0);
        drive(0, 1, 3, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 0, 0);
        drive(0, 0, 0, 8'h00, 64'h0, 1, 0, 0, 0);
        drive(0, 0, 0, 8'h00, 64'h0, 0, 1, 3, 0);
        idle(1);
        chk("merge_rdata", 0, o_rdata[0], 64'h1122_3344_AAAA_AAAA);
        chk("merge_rdv", 0, 64'(o_rdv[0]), 64'd1);
        chk("merge_rbank", 0, 64'(o_rbank[0]), 64'd0);

        // All banks full, then an illegal write.
        fill(0, 1);
        idle(1);
        chk("allfull_cnt", 0, 64'(o_cnt[0]), 64'd2);
        chk("allfull_avail", 0, 64'(o_avail[0]), 64'd0);
        drive(0, 1, 3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 0, 0);
        idle(1);
        chk("viol_err", 0, 64'(o_err[0]), 64'd1);
        drive(0, 0, 0, 8'h00, 64'h0, 0, 0, 0, 1);
        idle(1);
        chk("release_avail", 0, 64'(o_avail[0]), 64'd1);
        chk("release_wbank", 0, 64'(o_wbank[0]), 64'd0);

        // Commit and release together with one bank full.
        drive(0, 0, 0, 8'h00, 64'h0, 1, 0, 0, 1);
        idle(1);
        chk("pp_cnt", 0, 64'(o_cnt[0]), 64'd1);
        chk("pp_wbank", 0, 64'(o_wbank[0]), 64'd1);
        chk("pp_rbank", 0, 64'(o_rbank[0]), 64'd0);
        drive(0, 0, 0, 8'h00, 64'h0, 0, 1, 3, 0);
        idle(1);
        chk("noviol_rdata", 0, o_rdata[0], 64'h1122_3344_AAAA_AAAA);

        // Reset lands on the same edge as a read.
        drive(0, 0, 0, 8'h00, 64'h0, 0, 1, 3, 0);
        rst = 1'b1;
        idle(1);
        chk("rst_cnt", 0, 64'(o_cnt[0]), 64'd0);
        chk("rst_avail", 0, 64'(o_avail[0]), 64'd1);
        chk("rst_valid", 0, 64'(o_valid[0]), 64'd0);
        chk("rst_err", 0, 64'(o_err[0]), 64'd0);
        chk("rst_rdata", 0, o_rdata[0], 64'h0);
        chk("rst_rdv", 0, 64'(o_rdv[0]), 64'd0);
        chk("rst_rbank", 0, 64'(o_rbank[0]), 64'd0);

        // Three-bank instance: 7 rounds, data returned in commit order.
        fill(1, 0);
        for (int r = 1; r <= 7; r++) begin
            if (r < 7) fill(1, r);
            drain(1, r - 1);
            if (r == 3) begin
                idle(1);
                chk("wrap_rbank", 1, 64'(o_rbank[1]), 64'd0);
            end
        end
        idle(1);
        chk("rounds_cnt", 1, 64'(o_cnt[1]), 64'd0);

        // Random legal traffic, then an illegal read on an empty buffer.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            clr();
            rst = 1'b1;
            idle(1);
            repeat (400) rand_cycle(c);
            idle(1);
            chk("rand_err", c, 64'(o_err[c]), 64'd0);
            @(negedge clk);
            clr();
            rst = 1'b1;
            drive(c, 0, 0, 8'h00, 64'h0, 0, 1, 0, 0);
            idle(1);
            chk("empty_read_err", c, 64'(o_err[c]), 64'd1);
            chk("empty_read_rdv", c, 64'(o_rdv[c]), 64'd0);
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aidc_lite_comp_pingpong_buf.md
Name: aidc_lite_comp_pingpong_buf

Overview:
Parametrised multi-bank staging buffer between the AIDC Lite compression engine's AHB fetch path and the compressor core. It generalises the single 16x64 byte-enabled buffer to NUM_BANKS banks of DEPTH x DATA_W words. Bank ownership passes between the fill side and the drain side through commit/release handshakes, so AHB fetch of block N+1 overlaps compression of block N.

Parameters:
DATA_W, 64, word width in bits; multiple of 8, >= 8
DEPTH, 16, words per bank; power of two, >= 2
NUM_BANKS, 2, number of banks; >= 2
ADDR_W, $clog2(DEPTH), derived word-address width; not overridden
BE_W, DATA_W/8, derived byte-enable width

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
wr_avail_o  output  1  bank at wr_ptr is FREE; fill side may write and commit
wr_bank_o  output  $clog2(NUM_BANKS)  index of current fill bank (wr_ptr)
wren_i  input  1  write strobe
waddr_i  input  ADDR_W  word address within fill bank
wbe_i  input  BE_W  byte enables; bit k covers wdata_i[8k+7:8k]
wdata_i  input  DATA_W  write data
wr_commit_i  input  1  fill bank complete; hand it to the drain side
rd_valid_o  output  1  bank at rd_ptr is FULL; drain side may read and release
rd_bank_o  output  $clog2(NUM_BANKS)  index of current drain bank (rd_ptr)
rden_i  input  1  read strobe
raddr_i  input  ADDR_W  word address within drain bank
rdata_o  output  DATA_W  read data, registered
rdata_valid_o  output  1  rdata_o is updated this cycle
rd_release_i  input  1  drain bank consumed; return it to FREE
full_cnt_o  output  $clog2(NUM_BANKS+1)  number of FULL banks
err_o  output  1  sticky protocol-violation flag

Behaviour:
- State: per-bank 1-bit state, FREE=0 / FULL=1. wr_ptr, rd_ptr count 0..NUM_BANKS-1 and wrap to 0 after NUM_BANKS-1; there is no power-of-two assumption on NUM_BANKS.
- Reset (rst=1 at clk edge): all banks FREE, wr_ptr=rd_ptr=0. Outputs: wr_avail_o=1, rd_valid_o=0, wr_bank_o=0, rd_bank_o=0, rdata_o=0, rdata_valid_o=0, full_cnt_o=0, err_o=0. Memory contents are not reset. Reset mid-transfer discards all bank contents and ownership.
- wr_avail_o = ~state[wr_ptr]; rd_valid_o = state[rd_ptr]; full_cnt_o = popcount(state). All three are combinational from registers.
- Write: if wren_i && wr_avail_o, bytes with wbe_i[k]=1 of mem[wr_ptr][waddr_i] are updated at the clock edge; other bytes are unchanged. wbe_i=0 is a legal no-op.
- Commit: if wr_commit_i && wr_avail_o, then state[wr_ptr]<=FULL and wr_ptr<=wr_ptr+1 (wrapping). A write in the same cycle lands in the old bank before the handoff.
- Read: if rden_i && rd_valid_o, then rdata_o<=mem[rd_ptr][raddr_i] and rdata_valid_o<=1 on the next cycle (1-cycle latency). Otherwise rdata_valid_o<=0 and rdata_o holds its value.
- Release: if rd_release_i && rd_valid_o, then state[rd_ptr]<=FREE and rd_ptr<=rd_ptr+1. A read in the same cycle uses the old bank.
- Commit and release in the same cycle always act on different banks (one is FREE, one is FULL); both take effect. full_cnt_o is unchanged by that pair.
- Read and write never target the same bank, so there is no read/write collision case.
- Violations are ignored (no state or memory change) and set err_o=1: wren_i or wr_commit_i while !wr_avail_o; rden_i or rd_release_i while !rd_valid_o. err_o clears only on rst.
- All-full: full_cnt_o=NUM_BANKS, wr_avail_o=0. All-empty: full_cnt_o=0, rd_valid_o=0.

Test Plan:
- Reset, then idle -> wr_avail_o=1, rd_valid_o=0, full_cnt_o=0, err_o=0, rdata_valid_o=0.
- Write bank0 addr3 data 0x1122334455667788 wbe=0xFF, then addr3 data 0xAAAA... wbe=0x0F, commit, read addr3 -> one cycle later rdata_o=0x11223344AAAAAAAA, rdata_valid_o=1, rd_bank_o=0.
- Fill and commit both banks (NUM_BANKS=2) -> full_cnt_o=2, wr_avail_o=0. Then wren_i=1 -> err_o=1 and no memory change; release -> wr_avail_o=1, wr_bank_o=0.
- Steady ping-pong: commit and release in the same cycle with full_cnt_o=1 -> full_cnt_o stays 1; both pointers advance and wrap 1->0.
- NUM_BANKS=3, DATA_W=32, DEPTH=8: 7 commit/release rounds with distinct data per bank -> data read back in commit order, and pointers wrap 2->0.
- Assert rst while full_cnt_o=1 and a read is in flight -> next cycle all outputs are at reset values and rdata_valid_o=0.
